// File: rtl/alu_sequencer.sv
// Shares one ALU between N_REQ requesters: round-robin grant, one op in flight,
// valid/ready on both the request and the response side.
module alu_sequencer #(
  parameter int N_REQ   = 2,
  parameter int ALU_LAT = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [N_REQ-1:0]     i_req_valid,
  output logic [N_REQ-1:0]     o_req_ready,
  input  logic [8*N_REQ-1:0]   i_req_rd,
  input  logic [8*N_REQ-1:0]   i_req_ra,
  input  logic [5*N_REQ-1:0]   i_req_op,
  output logic [N_REQ-1:0]     o_rsp_valid,
  input  logic [N_REQ-1:0]     i_rsp_ready,
  output logic [7:0]           o_rsp_out,
  output logic                 o_rsp_cy,
  output logic                 o_rsp_zy,
  output logic                 o_en_alu,
  output logic [7:0]           o_RD,
  output logic [7:0]           o_RA,
  output logic [4:0]           o_aluop,
  input  logic [7:0]           i_alu_out,
  input  logic                 i_alu_cy,
  input  logic                 i_alu_zy,
  output logic                 o_busy,
  output logic [1:0]           o_dbg_state
);

  // Handshake rule on both sides: a transfer happens on a rising edge where
  // valid and ready are both high; the requester holds valid and data until then.

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(ALU_LAT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [7:0]       rd_q, rd_d;
  logic [7:0]       ra_q, ra_d;
  logic [4:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       out_q, out_d;
  logic             cy_q, cy_d;
  logic             zy_q, zy_d;

  logic [IDX_W-1:0] scan_idx;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
    if (v == IDX_W'(N_REQ - 1)) return '0;
    return v + IDX_W'(1);
  endfunction

  // First valid requester in the order ptr, ptr+1, ... wrapping at N_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = ptr_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (!pick_found && i_req_valid[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
      scan_idx = wrap_inc(scan_idx);
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    rd_d    = rd_q;
    ra_d    = ra_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    cy_d    = cy_q;
    zy_d    = zy_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          rd_d    = i_req_rd[8*pick_idx +: 8];
          ra_d    = i_req_ra[8*pick_idx +: 8];
          op_d    = i_req_op[5*pick_idx +: 5];
          grant_d = pick_idx;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_W'(ALU_LAT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // The ALU result is only guaranteed on the last wait cycle.
        if (cnt_q == CNT_W'(1)) begin
          out_d   = i_alu_out;
          cy_d    = i_alu_cy;
          zy_d    = i_alu_zy;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (i_rsp_ready[grant_q]) begin
          ptr_d   = wrap_inc(grant_q);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      rd_q    <= '0;
      ra_q    <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      cy_q    <= 1'b0;
      zy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      rd_q    <= rd_d;
      ra_q    <= ra_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      cy_q    <= cy_d;
      zy_q    <= zy_d;
    end
  end

  assign o_req_ready = (state_q == S_IDLE && pick_found) ? (N_REQ'(1) << pick_idx) : '0;
  assign o_rsp_valid = (state_q == S_RESP) ? (N_REQ'(1) << grant_q) : '0;
  assign o_rsp_out   = out_q;
  assign o_rsp_cy    = cy_q;
  assign o_rsp_zy    = zy_q;
  assign o_en_alu    = (state_q == S_ISSUE);
  assign o_RD        = rd_q;
  assign o_RA        = ra_q;
  assign o_aluop     = op_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: two instances (ALU_LAT=1 and ALU_LAT=3), each with a
// pipelined ALU model, and a scoreboard of expected responses.
module tb_alu_sequencer;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          total = 0;
  int          bad = 0;
  int          model_ptr = 0;
  int          cyc_n = 0;

  // instance with ALU_LAT=1
  logic [1:0]  req_valid = '0, rsp_ready = '0;
  logic [15:0] req_rd = '0, req_ra = '0;
  logic [9:0]  req_op = '0;
  logic [1:0]  req_ready, rsp_valid, dbg;
  logic [7:0]  rsp_out, rd_o, ra_o, alu_out;
  logic        rsp_cy, rsp_zy, en_alu, alu_cy, alu_zy, busy;
  logic [4:0]  aluop;

  // instance with ALU_LAT=3
  logic [1:0]  req_valid_3 = '0, rsp_ready_3 = '0;
  logic [15:0] req_rd_3 = '0, req_ra_3 = '0;
  logic [9:0]  req_op_3 = '0;
  logic [1:0]  req_ready_3, rsp_valid_3, dbg_3;
  logic [7:0]  rsp_out_3, rd_o_3, ra_o_3, alu_out_3;
  logic        rsp_cy_3, rsp_zy_3, en_alu_3, alu_cy_3, alu_zy_3, busy_3;
  logic [4:0]  aluop_3;

  // scoreboard entry: {requester index, cy, zy, out}
  logic [10:0] exp_q[$];

  alu_sequencer #(.N_REQ(2), .ALU_LAT(1)) u_dut (
    .i_clk(clk), .i_reset(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_rd(req_rd), .i_req_ra(req_ra), .i_req_op(req_op),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_out(rsp_out), .o_rsp_cy(rsp_cy), .o_rsp_zy(rsp_zy),
    .o_en_alu(en_alu), .o_RD(rd_o), .o_RA(ra_o), .o_aluop(aluop),
    .i_alu_out(alu_out), .i_alu_cy(alu_cy), .i_alu_zy(alu_zy),
    .o_busy(busy), .o_dbg_state(dbg)
  );

  alu_sequencer #(.N_REQ(2), .ALU_LAT(3)) u_dut3 (
    .i_clk(clk), .i_reset(rst),
    .i_req_valid(req_valid_3), .o_req_ready(req_ready_3),
    .i_req_rd(req_rd_3), .i_req_ra(req_ra_3), .i_req_op(req_op_3),
    .o_rsp_valid(rsp_valid_3), .i_rsp_ready(rsp_ready_3),
    .o_rsp_out(rsp_out_3), .o_rsp_cy(rsp_cy_3), .o_rsp_zy(rsp_zy_3),
    .o_en_alu(en_alu_3), .o_RD(rd_o_3), .o_RA(ra_o_3), .o_aluop(aluop_3),
    .i_alu_out(alu_out_3), .i_alu_cy(alu_cy_3), .i_alu_zy(alu_zy_3),
    .o_busy(busy_3), .o_dbg_state(dbg_3)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // ---------------- ALU model: {cy, zy, out} ----------------
  function automatic logic [9:0] alu_f(input logic [7:0] rd, input logic [7:0] ra,
                                       input logic [4:0] op);
    logic [8:0] s;
    case (op)
      5'd0:    s = {1'b0, rd} + {1'b0, ra};
      5'd1:    s = {1'b0, rd} - {1'b0, ra};
      default: s = {1'b0, rd & ra};
    endcase
    return {s[8], (s[7:0] == 8'h00), s[7:0]};
  endfunction

  // Result appears ALU_LAT edges after the enable edge; filler value elsewhere.
  logic [9:0] p1 = 10'h3A5, p3a = 10'h3A5, p3b = 10'h3A5, p3c = 10'h3A5;
  always @(posedge clk) begin
    p1  <= en_alu   ? alu_f(rd_o, ra_o, aluop)       : 10'h3A5;
    p3a <= en_alu_3 ? alu_f(rd_o_3, ra_o_3, aluop_3) : 10'h3A5;
    p3b <= p3a;
    p3c <= p3b;
  end
  assign {alu_cy, alu_zy, alu_out}       = p1;
  assign {alu_cy_3, alu_zy_3, alu_out_3} = p3c;

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int k);
    req_rd[8*k +: 8] = 8'($urandom_range(0, 255));
    req_ra[8*k +: 8] = 8'($urandom_range(0, 255));
    req_op[5*k +: 5] = 5'($urandom_range(0, 2));
  endtask

  function automatic logic [10:0] sb_pop();
    if (exp_q.size() == 0) return 11'h7FF;
    return exp_q.pop_front();
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0;
    repeat (3) cyc();
    total++; if ({req_ready, rsp_valid} !== 4'h0) begin bad++; $display("FAIL rst_hs: got %h want 0", {req_ready, rsp_valid}); end
    total++; if ({en_alu, rd_o, ra_o, aluop} !== 22'h0) begin bad++; $display("FAIL rst_alu: got %h want 0", {en_alu, rd_o, ra_o, aluop}); end
    total++; if ({rsp_cy, rsp_zy, rsp_out} !== 10'h0) begin bad++; $display("FAIL rst_rsp: got %h want 0", {rsp_cy, rsp_zy, rsp_out}); end
    total++; if ({busy, dbg} !== 3'h0) begin bad++; $display("FAIL rst_busy: got %h want 0", {busy, dbg}); end
    total++; if ({req_ready_3, rsp_valid_3, en_alu_3, busy_3, rsp_out_3} !== 14'h0) begin bad++; $display("FAIL rst_dut3: got %h want 0", {req_ready_3, rsp_valid_3, en_alu_3, busy_3, rsp_out_3}); end
    rst = 1'b0;
    cyc();
    total++; if ({busy, req_ready, rsp_valid} !== 5'h0) begin bad++; $display("FAIL rst_release: got %h want 0", {busy, req_ready, rsp_valid}); end
  endtask

  task automatic test_single();
    logic [10:0] e;
    cyc();
    req_rd[7:0] = 8'h0F; req_ra[7:0] = 8'h01; req_op[4:0] = OP_ADD;
    req_valid = 2'b01; rsp_ready = 2'b01;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL single_grant: got %b want 01", req_ready); end
    exp_q.push_back({1'b0, alu_f(8'h0F, 8'h01, OP_ADD)});
    cyc();
    req_valid = '0;
    total++; if (en_alu !== 1'b1) begin bad++; $display("FAIL single_en: got %b want 1", en_alu); end
    total++; if ({rd_o, ra_o, aluop} !== {8'h0F, 8'h01, OP_ADD}) begin bad++; $display("FAIL single_operands: got %h want %h", {rd_o, ra_o, aluop}, {8'h0F, 8'h01, OP_ADD}); end
    total++; if ({busy, req_ready} !== 3'b100) begin bad++; $display("FAIL single_busy: got %b want 100", {busy, req_ready}); end
    cyc();
    total++; if ({en_alu, rsp_valid, dbg} !== {1'b0, 2'b00, ST_WAIT}) begin bad++; $display("FAIL single_wait: got %b want %b", {en_alu, rsp_valid, dbg}, {1'b0, 2'b00, ST_WAIT}); end
    cyc();
    e = sb_pop();
    total++; if (rsp_valid !== (2'b01 << e[10])) begin bad++; $display("FAIL single_rsp_valid: got %b want %b", rsp_valid, 2'b01 << e[10]); end
    total++; if ({rsp_cy, rsp_zy, rsp_out} !== e[9:0]) begin bad++; $display("FAIL single_rsp_data: got %h want %h", {rsp_cy, rsp_zy, rsp_out}, e[9:0]); end
    total++; if (en_alu !== 1'b0) begin bad++; $display("FAIL single_en_pulse: got %b want 0", en_alu); end
    cyc();
    total++; if ({busy, rsp_valid} !== 3'b000) begin bad++; $display("FAIL single_idle: got %b want 000", {busy, rsp_valid}); end
    model_ptr = 1;
  endtask

  task automatic test_round_robin();
    int c;
    int g;
    logic [10:0] e;
    logic [1:0] last_ready;
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    model_ptr = 0;
    set_req(0); set_req(1);
    req_valid = 2'b11; rsp_ready = 2'b11;
    last_ready = '0;
    for (int n = 0; n < 4; n++) begin
      #1;
      c = 0;
      while (req_ready == 2'b00 && c < 10) begin cyc(); c++; end
      g = model_ptr;
      total++; if (req_ready !== (2'b01 << g)) begin bad++; $display("FAIL rr_grant: got %b want %b", req_ready, 2'b01 << g); end
      total++; if (req_ready === last_ready) begin bad++; $display("FAIL rr_repeat: got %b want not %b", req_ready, last_ready); end
      last_ready = req_ready;
      exp_q.push_back({1'(g), alu_f(req_rd[8*g +: 8], req_ra[8*g +: 8], req_op[5*g +: 5])});
      cyc();
      set_req(g);
      c = 0;
      while (rsp_valid == 2'b00 && c < 10) begin cyc(); c++; end
      e = sb_pop();
      total++; if (rsp_valid !== (2'b01 << e[10])) begin bad++; $display("FAIL rr_route: got %b want %b", rsp_valid, 2'b01 << e[10]); end
      total++; if ({rsp_cy, rsp_zy, rsp_out} !== e[9:0]) begin bad++; $display("FAIL rr_data: got %h want %h", {rsp_cy, rsp_zy, rsp_out}, e[9:0]); end
      model_ptr = (g + 1) % 2;
      cyc();
    end
    req_valid = '0;
    cyc();
  endtask

  task automatic test_backpressure();
    int c;
    int g;
    logic [10:0] e;
    logic [1:0] hold_valid;
    set_req(0); set_req(1);
    req_valid = 2'b11; rsp_ready = 2'b00;
    #1;
    g = model_ptr;
    total++; if (req_ready !== (2'b01 << g)) begin bad++; $display("FAIL bp_grant: got %b want %b", req_ready, 2'b01 << g); end
    exp_q.push_back({1'(g), alu_f(req_rd[8*g +: 8], req_ra[8*g +: 8], req_op[5*g +: 5])});
    cyc();
    c = 0;
    while (rsp_valid == 2'b00 && c < 10) begin cyc(); c++; end
    e = (exp_q.size() != 0) ? exp_q[0] : 11'h7FF;
    hold_valid = 2'b01 << e[10];
    rsp_ready = ~hold_valid;
    for (int i = 0; i < 5; i++) begin
      total++; if ({rsp_valid, rsp_cy, rsp_zy, rsp_out} !== {hold_valid, e[9:0]}) begin bad++; $display("FAIL bp_hold: got %h want %h", {rsp_valid, rsp_cy, rsp_zy, rsp_out}, {hold_valid, e[9:0]}); end
      total++; if ({req_ready, en_alu} !== 3'b000) begin bad++; $display("FAIL bp_stall: got %b want 000", {req_ready, en_alu}); end
      cyc();
    end
    rsp_ready = 2'b11;
    e = sb_pop();
    cyc();
    model_ptr = (g + 1) % 2;
    total++; if ({busy, req_ready} !== {1'b0, 2'b01 << model_ptr}) begin bad++; $display("FAIL bp_next_grant: got %b want %b", {busy, req_ready}, {1'b0, 2'b01 << model_ptr}); end
    req_valid = '0;
    cyc();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_idle: got %b want 0", busy); end
  endtask

  task automatic test_reset_wait();
    int c;
    logic [10:0] e;
    set_req(1);
    req_valid = 2'b10; rsp_ready = 2'b11;
    #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL rw_grant: got %b want 10", req_ready); end
    cyc();
    req_valid = '0;
    total++; if (en_alu !== 1'b1) begin bad++; $display("FAIL rw_issue: got %b want 1", en_alu); end
    cyc();
    total++; if (dbg !== ST_WAIT) begin bad++; $display("FAIL rw_wait: got %0d want %0d", dbg, ST_WAIT); end
    rst = 1'b1;
    cyc();
    total++; if ({dbg, busy, rsp_valid, en_alu} !== {ST_IDLE, 4'b0000}) begin bad++; $display("FAIL rw_after_reset: got %b want 000000", {dbg, busy, rsp_valid, en_alu}); end
    rst = 1'b0;
    model_ptr = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL rw_no_rsp: got %b want 00", rsp_valid); end
    end
    set_req(0); set_req(1);
    req_valid = 2'b11;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rw_grant_after: got %b want 01", req_ready); end
    exp_q.push_back({1'b0, alu_f(req_rd[7:0], req_ra[7:0], req_op[4:0])});
    cyc();
    req_valid = '0;
    c = 0;
    while (rsp_valid == 2'b00 && c < 10) begin cyc(); c++; end
    e = sb_pop();
    total++; if ({rsp_valid, rsp_cy, rsp_zy, rsp_out} !== {2'b01 << e[10], e[9:0]}) begin bad++; $display("FAIL rw_rsp: got %h want %h", {rsp_valid, rsp_cy, rsp_zy, rsp_out}, {2'b01 << e[10], e[9:0]}); end
    model_ptr = 1;
    cyc();
  endtask

  task automatic test_back_to_back();
    int c;
    int t;
    int t_prev;
    logic [10:0] e;
    set_req(1);
    req_valid = 2'b10; rsp_ready = 2'b11;
    t_prev = 0;
    for (int n = 0; n < 3; n++) begin
      #1;
      c = 0;
      while (req_ready == 2'b00 && c < 10) begin cyc(); c++; end
      total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL b2b_grant: got %b want 10", req_ready); end
      t = cyc_n;
      if (n > 0) begin
        total++; if (t - t_prev !== 4) begin bad++; $display("FAIL b2b_gap: got %0d want 4", t - t_prev); end
      end
      t_prev = t;
      exp_q.push_back({1'b1, alu_f(req_rd[15:8], req_ra[15:8], req_op[9:5])});
      cyc();
      set_req(1);
      c = 0;
      while (rsp_valid == 2'b00 && c < 10) begin cyc(); c++; end
      e = sb_pop();
      total++; if (rsp_valid !== (2'b01 << e[10])) begin bad++; $display("FAIL b2b_route: got %b want %b", rsp_valid, 2'b01 << e[10]); end
      total++; if ({rsp_cy, rsp_zy, rsp_out} !== e[9:0]) begin bad++; $display("FAIL b2b_data: got %h want %h", {rsp_cy, rsp_zy, rsp_out}, e[9:0]); end
      cyc();
    end
    req_valid = '0;
    cyc();
  endtask

  task automatic test_lat3();
    logic [10:0] e;
    req_rd_3[7:0] = 8'hFF; req_ra_3[7:0] = 8'h01; req_op_3[4:0] = OP_ADD;
    req_valid_3 = 2'b01; rsp_ready_3 = 2'b01;
    #1;
    total++; if (req_ready_3 !== 2'b01) begin bad++; $display("FAIL l3_grant: got %b want 01", req_ready_3); end
    exp_q.push_back({1'b0, alu_f(8'hFF, 8'h01, OP_ADD)});
    cyc();
    req_valid_3 = '0;
    total++; if ({en_alu_3, rd_o_3, ra_o_3} !== {1'b1, 8'hFF, 8'h01}) begin bad++; $display("FAIL l3_issue: got %h want %h", {en_alu_3, rd_o_3, ra_o_3}, {1'b1, 8'hFF, 8'h01}); end
    for (int i = 2; i <= 4; i++) begin
      cyc();
      total++; if ({rsp_valid_3, en_alu_3} !== 3'b000) begin bad++; $display("FAIL l3_wait: cycle T0+%0d got %b want 000", i, {rsp_valid_3, en_alu_3}); end
    end
    cyc();
    e = sb_pop();
    total++; if (rsp_valid_3 !== (2'b01 << e[10])) begin bad++; $display("FAIL l3_valid: got %b want %b", rsp_valid_3, 2'b01 << e[10]); end
    total++; if ({rsp_cy_3, rsp_zy_3, rsp_out_3} !== e[9:0]) begin bad++; $display("FAIL l3_data: got %h want %h", {rsp_cy_3, rsp_zy_3, rsp_out_3}, e[9:0]); end
    cyc();
    total++; if (busy_3 !== 1'b0) begin bad++; $display("FAIL l3_idle: got %b want 0", busy_3); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_wait();
    test_back_to_back();
    test_lat3();
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL sb_drain: got %0d want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
